// File: rtl/buf_dma_pkg.sv
// Shared types and constants for buf_dma_engine (state encoding, latched command fields).
// Struct field widths match the engine's default parameters.
package buf_dma_pkg;
    localparam int DMA_EXT_AW    = 32;
    localparam int DMA_BUF_AW    = 10;
    localparam int DMA_LEN_W     = 32;
    localparam int DMA_N_BUF     = 16;
    localparam int DMA_LOG_N_BUF = 4;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_SAVE = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} dma_state_t;

    typedef struct packed {
        logic                     dir;
        logic                     set;
        logic [DMA_LOG_N_BUF-1:0] bank;
        logic [DMA_EXT_AW-1:0]    stride;
        logic [DMA_BUF_AW-1:0]    buf_start;
        logic [DMA_LEN_W-1:0]     words;
    } dma_cmd_t;

    function automatic logic [DMA_N_BUF-1:0] bank_onehot(input logic [DMA_LOG_N_BUF-1:0] b);
        return DMA_N_BUF'(1) << b;
    endfunction
endpackage

// File: rtl/dma_lat_pipe.sv
// Read-latency valid shift register: a read pushed now pops RD_LAT cycles later.
// cnt_o is the number of reads currently in flight.
module dma_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = $clog2(RD_LAT + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    output logic             pop_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        vld_d = (vld_q << 1) | RD_LAT'(push_i);
        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(vld_q[RD_LAT-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_o = vld_q[RD_LAT-1];
    assign cnt_o = cnt_q;
endmodule

// File: rtl/buf_dma_engine.sv
// Block mover between external memory and one buffer bank, one word per cycle.
// Optional running checksum of written words when BUF_DMA_CHECKSUM_EN is defined.
module buf_dma_engine
    import buf_dma_pkg::*;
#(
    parameter int DW        = 16,
    parameter int EXT_AW    = DMA_EXT_AW,
    parameter int BUF_AW    = DMA_BUF_AW,
    parameter int N_BUF     = DMA_N_BUF,
    parameter int LOG_N_BUF = DMA_LOG_N_BUF,
    parameter int LEN_W     = DMA_LEN_W,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic                 cmd_set,
    input  logic [LOG_N_BUF-1:0] cmd_bank,
    input  logic [EXT_AW-1:0]    cmd_ext_start,
    input  logic [EXT_AW-1:0]    cmd_ext_stride,
    input  logic [BUF_AW-1:0]    cmd_buf_start,
    input  logic [LEN_W-1:0]     cmd_words,
    output logic                 busy,
    output logic                 done,
`ifdef BUF_DMA_CHECKSUM_EN
    output logic [DW-1:0]        checksum,
`endif
    output logic                 ext_re,
    output logic [EXT_AW-1:0]    ext_rd_addr,
    input  logic [DW-1:0]        ext_rd_data,
    output logic                 ext_we,
    output logic [EXT_AW-1:0]    ext_wr_addr,
    output logic [DW-1:0]        ext_wr_data,
    output logic [N_BUF-1:0]     buf1_w_en,
    output logic [N_BUF-1:0]     buf2_w_en,
    output logic [N_BUF-1:0]     buf1_r_en,
    output logic [N_BUF-1:0]     buf2_r_en,
    output logic [BUF_AW-1:0]    buf_w_addr,
    output logic [DW-1:0]        buf_w_data,
    output logic [BUF_AW-1:0]    buf_r_addr,
    input  logic [DW-1:0]        buf1_r_data,
    input  logic [DW-1:0]        buf2_r_data
);
    localparam int PIPE_CW = $clog2(RD_LAT + 1) + 1;

    dma_state_t          state_q, state_d;
    dma_cmd_t            cmd_q, cmd_d;
    logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [EXT_AW-1:0]   rd_acc_q, rd_acc_d;
    logic [EXT_AW-1:0]   wr_acc_q, wr_acc_d;
    logic                accept, issuing, last_issue, is_load, wr_vld;
    logic [PIPE_CW-1:0]  pipe_cnt;
    logic [N_BUF-1:0]    oh;
    logic [DW-1:0]       wr_word;

    assign accept     = cmd_valid & cmd_ready;
    assign issuing    = (state_q == ISSUE);
    assign last_issue = issuing && (issue_cnt_q == cmd_q.words - LEN_W'(1));
    assign is_load    = (cmd_q.dir == DIR_LOAD);
    assign oh         = bank_onehot(cmd_q.bank);
    assign wr_word    = is_load ? ext_rd_data : (cmd_q.set ? buf2_r_data : buf1_r_data);

    dma_lat_pipe #(.RD_LAT(RD_LAT), .CNT_W(PIPE_CW)) u_lat_pipe (
        .clk    (clk),
        .rst    (rst),
        .push_i (issuing),
        .pop_o  (wr_vld),
        .cnt_o  (pipe_cnt)
    );

    // Both address streams are running accumulators, so stride never needs a multiplier.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_acc_d    = rd_acc_q;
        wr_acc_d    = wr_acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d.dir       = cmd_dir;
                    cmd_d.set       = cmd_set;
                    cmd_d.bank      = cmd_bank;
                    cmd_d.stride    = cmd_ext_stride;
                    cmd_d.buf_start = cmd_buf_start;
                    cmd_d.words     = cmd_words;
                    issue_cnt_d     = '0;
                    wr_cnt_d        = '0;
                    rd_acc_d        = cmd_ext_start;
                    wr_acc_d        = cmd_ext_start;
                    state_d         = (cmd_words == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + LEN_W'(1);
                rd_acc_d    = rd_acc_q + cmd_q.stride;
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave once the only read still in flight is the one writing back now.
                if (pipe_cnt == PIPE_CW'(wr_vld)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wr_vld) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            wr_acc_d = wr_acc_q + cmd_q.stride;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            rd_acc_q    <= '0;
            wr_acc_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_acc_q    <= rd_acc_d;
            wr_acc_q    <= wr_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_q <= cmd_d;
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Issue stage drives read ports; write stage drives when the latency pipe pops.
    always_comb begin
        ext_re      = 1'b0;
        ext_rd_addr = '0;
        buf1_r_en   = '0;
        buf2_r_en   = '0;
        buf_r_addr  = '0;
        ext_we      = 1'b0;
        ext_wr_addr = '0;
        ext_wr_data = '0;
        buf1_w_en   = '0;
        buf2_w_en   = '0;
        buf_w_addr  = '0;
        buf_w_data  = '0;
        if (issuing) begin
            if (is_load) begin
                ext_re      = 1'b1;
                ext_rd_addr = rd_acc_q;
            end else begin
                buf1_r_en  = cmd_q.set ? '0 : oh;
                buf2_r_en  = cmd_q.set ? oh : '0;
                buf_r_addr = cmd_q.buf_start + issue_cnt_q[BUF_AW-1:0];
            end
        end
        if (wr_vld) begin
            if (is_load) begin
                buf1_w_en  = cmd_q.set ? '0 : oh;
                buf2_w_en  = cmd_q.set ? oh : '0;
                buf_w_addr = cmd_q.buf_start + wr_cnt_q[BUF_AW-1:0];
                buf_w_data = wr_word;
            end else begin
                ext_we      = 1'b1;
                ext_wr_addr = wr_acc_q;
                ext_wr_data = wr_word;
            end
        end
    end

`ifdef BUF_DMA_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept)      csum_d = '0;
        else if (wr_vld) csum_d = csum_q + wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) csum_q <= '0;
        else      csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_buf_dma_engine.sv
// Scoreboard bench for buf_dma_engine at RD_LAT=2 (done latency N+RD_LAT+1, so 7 cycles for 4 words).
// Checksum comparisons are active when BUF_DMA_CHECKSUM_EN is defined.
module tb_buf_dma_engine;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic        cmd_dir = 1'b0, cmd_set = 1'b0;
    logic [3:0]  cmd_bank = '0;
    logic [31:0] cmd_ext_start = '0, cmd_ext_stride = '0;
    logic [9:0]  cmd_buf_start = '0;
    logic [31:0] cmd_words = '0;
    logic        busy, done;
    logic        ext_re, ext_we;
    logic [31:0] ext_rd_addr, ext_wr_addr;
    logic [15:0] ext_rd_data, ext_wr_data;
    logic [15:0] buf1_w_en, buf2_w_en, buf1_r_en, buf2_r_en;
    logic [9:0]  buf_w_addr, buf_r_addr;
    logic [15:0] buf_w_data, buf1_r_data, buf2_r_data;
`ifdef BUF_DMA_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    buf_dma_engine #(.RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_set(cmd_set), .cmd_bank(cmd_bank),
        .cmd_ext_start(cmd_ext_start), .cmd_ext_stride(cmd_ext_stride),
        .cmd_buf_start(cmd_buf_start), .cmd_words(cmd_words),
        .busy(busy), .done(done),
`ifdef BUF_DMA_CHECKSUM_EN
        .checksum(checksum),
`endif
        .ext_re(ext_re), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
        .ext_we(ext_we), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .buf1_w_en(buf1_w_en), .buf2_w_en(buf2_w_en),
        .buf1_r_en(buf1_r_en), .buf2_r_en(buf2_r_en),
        .buf_w_addr(buf_w_addr), .buf_w_data(buf_w_data),
        .buf_r_addr(buf_r_addr),
        .buf1_r_data(buf1_r_data), .buf2_r_data(buf2_r_data)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [63:0] v;
    } ev_t;
    ev_t q_ext_rd[$], q_buf_rd[$], q_buf_wr[$], q_ext_wr[$], q_done[$];

    logic [15:0] ext_ovr [logic [31:0]];

    function automatic logic [15:0] ext_val(input logic [31:0] a);
        if (ext_ovr.exists(a)) return ext_ovr[a];
        return a[15:0] ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] buf_val(input logic s, input logic [3:0] b, input logic [9:0] a);
        return {a, 1'b0, s, b};
    endfunction

    function automatic logic [3:0] oh_idx(input logic [15:0] v);
        logic [3:0] r = '0;
        for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Memory models with RD_LAT cycles of read latency
    logic [15:0] ext_p [RD_LAT];
    logic [15:0] b1_p  [RD_LAT];
    logic [15:0] b2_p  [RD_LAT];
    always @(posedge clk) begin
        ext_p[0] <= ext_re ? ext_val(ext_rd_addr) : 16'h0;
        b1_p[0]  <= (buf1_r_en != 16'h0) ? buf_val(1'b0, oh_idx(buf1_r_en), buf_r_addr) : 16'h0;
        b2_p[0]  <= (buf2_r_en != 16'h0) ? buf_val(1'b1, oh_idx(buf2_r_en), buf_r_addr) : 16'h0;
        for (int i = 1; i < RD_LAT; i++) begin
            ext_p[i] <= ext_p[i-1];
            b1_p[i]  <= b1_p[i-1];
            b2_p[i]  <= b2_p[i-1];
        end
    end
    assign ext_rd_data = ext_p[RD_LAT-1];
    assign buf1_r_data = b1_p[RD_LAT-1];
    assign buf2_r_data = b2_p[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, ref ev_t q[$], input logic [63:0] act);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event at cyc %0d, got %h", name, cyc, act);
        end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.v !== act) begin
                errors++;
                $display("FAIL %s: got cyc %0d val %h, expected cyc %0d val %h", name, cyc, act, e.cyc, e.v);
            end
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues
    always @(negedge clk) begin
        if (ext_re) pop_cmp("ext_rd", q_ext_rd, {32'h0, ext_rd_addr});
        if ((buf1_r_en | buf2_r_en) != 16'h0)
            pop_cmp("buf_rd", q_buf_rd, {22'h0, buf1_r_en, buf2_r_en, buf_r_addr});
        if ((buf1_w_en | buf2_w_en) != 16'h0)
            pop_cmp("buf_wr", q_buf_wr, {6'h0, buf1_w_en, buf2_w_en, buf_w_addr, buf_w_data});
        if (ext_we) pop_cmp("ext_wr", q_ext_wr, {16'h0, ext_wr_addr, ext_wr_data});
`ifdef BUF_DMA_CHECKSUM_EN
        if (done) pop_cmp("done", q_done, {48'h0, checksum});
`else
        if (done) pop_cmp("done", q_done, 64'h0);
`endif
    end

    // Push expected events; cut >= 0 keeps only events up to that cycle and no done.
    task automatic expect_cmd(input logic dir, input logic set, input logic [3:0] bank,
                              input logic [31:0] es, input logic [31:0] st, input logic [9:0] bs,
                              input int n, input int acc, input int cut);
        logic [15:0] oh, e1, e2, d, cs;
        logic [31:0] ea;
        logic [9:0]  ba;
        int          rc, wc;
        oh = 16'h1 << bank;
        e1 = set ? 16'h0 : oh;
        e2 = set ? oh : 16'h0;
        cs = 16'h0;
        for (int i = 0; i < n; i++) begin
            ea = es + st * 32'(i);
            ba = bs + 10'(i);
            rc = acc + 1 + i;
            wc = rc + RD_LAT;
            if (dir == 1'b0) begin
                d = ext_val(ea);
                if (cut < 0 || rc <= cut) q_ext_rd.push_back('{rc, {32'h0, ea}});
                if (cut < 0 || wc <= cut) q_buf_wr.push_back('{wc, {6'h0, e1, e2, ba, d}});
            end else begin
                d = buf_val(set, bank, ba);
                if (cut < 0 || rc <= cut) q_buf_rd.push_back('{rc, {22'h0, e1, e2, ba}});
                if (cut < 0 || wc <= cut) q_ext_wr.push_back('{wc, {16'h0, ea, d}});
            end
            cs = cs + d;
        end
        if (cut < 0) begin
`ifdef BUF_DMA_CHECKSUM_EN
            q_done.push_back('{(n == 0) ? acc + 1 : acc + n + RD_LAT + 1, {48'h0, cs}});
`else
            q_done.push_back('{(n == 0) ? acc + 1 : acc + n + RD_LAT + 1, 64'h0});
`endif
        end
    endtask

    // Called at a negedge; returns 1 time unit after the accepting edge.
    task automatic send(input logic dir, input logic set, input logic [3:0] bank,
                        input logic [31:0] es, input logic [31:0] st, input logic [9:0] bs,
                        input logic [31:0] n, output int acc);
        cmd_dir = dir; cmd_set = set; cmd_bank = bank;
        cmd_ext_start = es; cmd_ext_stride = st; cmd_buf_start = bs; cmd_words = n;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept: cmd_ready not seen within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_ext_rd.size() == 0 && q_buf_rd.size() == 0 && q_buf_wr.size() == 0 &&
                q_ext_wr.size() == 0 && q_done.size() == 0 && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: transfer still pending after 300 cycles");
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'h1);
        chk({tag, "_busy_done"}, 64'({busy, done}), 64'h0);
        chk({tag, "_ext_en"}, 64'({ext_re, ext_we}), 64'h0);
        chk({tag, "_buf_en"}, {buf1_w_en, buf2_w_en, buf1_r_en, buf2_r_en}, 64'h0);
        chk({tag, "_ext_addr"}, {ext_rd_addr, ext_wr_addr}, 64'h0);
        chk({tag, "_misc"}, {12'h0, ext_wr_data, buf_w_addr, buf_w_data, buf_r_addr}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        // Load 4 words, set 1 bank 3, unit stride
        send(1'b0, 1'b0, 4'd3, 32'h100, 32'h1, 10'h0, 32'd4, acc);
        expect_cmd(1'b0, 1'b0, 4'd3, 32'h100, 32'h1, 10'h0, 4, acc, -1);
        chk("busy_t1", 64'(busy), 64'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();

        // Save 3 words, set 2 bank 0, stride 4, buffer address wraps
        send(1'b1, 1'b1, 4'd0, 32'h20, 32'h4, 10'h3FE, 32'd3, acc);
        expect_cmd(1'b1, 1'b1, 4'd0, 32'h20, 32'h4, 10'h3FE, 3, acc, -1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();

        // Zero-length command
        send(1'b0, 1'b0, 4'd5, 32'h500, 32'h1, 10'h0, 32'd0, acc);
        expect_cmd(1'b0, 1'b0, 4'd5, 32'h500, 32'h1, 10'h0, 0, acc, -1);
        chk("zero_ready_in_done", 64'(cmd_ready), 64'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("zero_ready_after", 64'(cmd_ready), 64'h1);
        wait_idle();

        // Second command queued behind a 2-word load with cmd_valid held high
        send(1'b0, 1'b0, 4'd15, 32'h40, 32'h2, 10'h10, 32'd2, acc1);
        expect_cmd(1'b0, 1'b0, 4'd15, 32'h40, 32'h2, 10'h10, 2, acc1, -1);
        @(negedge clk);
        send(1'b1, 1'b1, 4'd7, 32'h80, 32'hFFFF_FFFF, 10'h5, 32'd2, acc2);
        expect_cmd(1'b1, 1'b1, 4'd7, 32'h80, 32'hFFFF_FFFF, 10'h5, 2, acc2, -1);
        chk("queued_accept_cyc", 64'(acc2), 64'(acc1 + 2 + RD_LAT + 2));
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();

        // Reset after 2 of 8 issues
        send(1'b0, 1'b1, 4'd9, 32'h200, 32'h3, 10'h100, 32'd8, acc);
        expect_cmd(1'b0, 1'b1, 4'd9, 32'h200, 32'h3, 10'h100, 8, acc, acc + 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        rst = 1'b1;
        repeat (RD_LAT + 4) @(negedge clk);
        chk("midrst_no_pending", 64'(q_ext_rd.size() + q_buf_wr.size() + q_done.size()), 64'h0);

        // Fresh load after reset; data chosen so the checksum wraps to 0x0004
        ext_ovr[32'h300] = 16'hFFFF;
        ext_ovr[32'h301] = 16'h0002;
        ext_ovr[32'h302] = 16'h0003;
        send(1'b0, 1'b0, 4'd0, 32'h300, 32'h1, 10'h20, 32'd3, acc);
        expect_cmd(1'b0, 1'b0, 4'd0, 32'h300, 32'h1, 10'h20, 3, acc, -1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
`ifdef BUF_DMA_CHECKSUM_EN
        chk("checksum_hold", 64'(checksum), 64'h4);
`endif

        repeat (5) @(negedge clk);
        chk("q_ext_rd_empty", 64'(q_ext_rd.size()), 64'h0);
        chk("q_buf_rd_empty", 64'(q_buf_rd.size()), 64'h0);
        chk("q_buf_wr_empty", 64'(q_buf_wr.size()), 64'h0);
        chk("q_ext_wr_empty", 64'(q_ext_wr.size()), 64'h0);
        chk("q_done_empty", 64'(q_done.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/buf_dma_engine.md
Name: buf_dma_engine

Overview:
- Parametrised successor to the controller's MEM_LOAD/MEM_SAVE datapath. Moves blocks of words between external memory and one bank of buffer set 1 or set 2, in either direction.
- Adds a valid/ready command port, strided external addressing, explicit buffer start address, configurable read latency, and pipelined one-word-per-cycle throughput.
- Sits beside the computation controller. The top-level controller FSM issues commands decoded from regfile fields.

Parameters:
- DW, 16, data word width
- EXT_AW, 32, external memory address width
- BUF_AW, 10, buffer bank address width (ADDR_RAM)
- N_BUF, 16, banks per buffer set
- LOG_N_BUF, 4, clog2(N_BUF)
- LEN_W, 32, transfer length width
- RD_LAT, 1, read latency in cycles (>=1), shared by extmem and buffers

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low (asserted when 0, sampled on posedge clk)
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine can accept a command
- cmd_dir  in  1  0 = load (ext->buf), 1 = save (buf->ext)
- cmd_set  in  1  0 = buffer set 1, 1 = buffer set 2
- cmd_bank  in  LOG_N_BUF  target bank
- cmd_ext_start  in  EXT_AW  first external address
- cmd_ext_stride  in  EXT_AW  external address increment per word
- cmd_buf_start  in  BUF_AW  first buffer address
- cmd_words  in  LEN_W  word count
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes
- ext_re / ext_rd_addr / ext_rd_data  out / out / in  1 / EXT_AW / DW  external memory read
- ext_we / ext_wr_addr / ext_wr_data  out / out / out  1 / EXT_AW / DW  external memory write
- buf1_w_en, buf2_w_en  out  N_BUF  one-hot active-high bank write enables
- buf1_r_en, buf2_r_en  out  N_BUF  one-hot active-high bank read enables
- buf_w_addr / buf_w_data  out / out  BUF_AW / DW  write address and data (shared by both sets)
- buf_r_addr  out  BUF_AW  read address (shared)
- buf1_r_data, buf2_r_data  in  DW  bank read data, already muxed by bank

Behaviour:
- Reset (rst==0 at posedge):
  - state = IDLE; all counters = 0.
  - cmd_ready = 1; busy = 0; done = 0.
  - All enables = 0; all addresses and data outputs = 0.
  - Reset mid-transfer abandons the transfer with no done pulse.
- Command handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - All cmd_* fields are latched on acceptance.
  - cmd_ready = (state==IDLE).
- State machine:
  - IDLE -> ISSUE on accept when cmd_words != 0.
  - IDLE -> DONE on accept when cmd_words == 0; no memory access occurs.
  - ISSUE: one read issued per cycle, for issue_cnt 0..words-1.
    - Load: ext_re = 1, ext_rd_addr = start + issue_cnt*stride (mod 2^EXT_AW).
    - Save: selected set's r_en[bank] = 1, buf_r_addr = buf_start + issue_cnt (mod 2^BUF_AW, wraps silently).
    - After the last issue -> DRAIN.
  - DRAIN: waits until all in-flight reads have returned -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
  - busy = 1 in ISSUE, DRAIN and DONE.
- Return pipeline:
  - An RD_LAT-deep valid shift register, plus write counter wr_cnt, tracks outstanding reads.
  - Read data is written in the cycle its valid emerges, i.e. RD_LAT cycles after the matching issue.
  - Load: selected set's w_en[bank] = 1, buf_w_addr = buf_start + wr_cnt, buf_w_data = ext_rd_data.
  - Save: ext_we = 1, ext_wr_addr = start + wr_cnt*stride, ext_wr_data = buf1_r_data or buf2_r_data per the latched set.
- Timing:
  - Throughput is 1 word per cycle.
  - For N>0, done is asserted N + RD_LAT + 1 cycles after the accept cycle.
- Width rules:
  - Stride multiply is implemented as a running accumulator, not a multiplier; all address arithmetic truncates modulo the port width.
  - stride == 0 is legal (repeated reads/writes to one external address).
- Enables of the unselected set, and of all unselected banks, stay 0 at all times.
- A command presented while busy is held off; cmd_ready remains 0 until the cycle after done.

Optional Feature:
- Macro BUF_DMA_CHECKSUM_EN.
- When defined:
  - Extra output port checksum [DW].
  - It is cleared on command accept.
  - It accumulates every written data word, sum modulo 2^DW.
  - It is stable from the done cycle until the next accept; its reset value is 0.
- When undefined, the port and accumulator are absent and all other behaviour is identical.

Decomposition:
- Package buf_dma_pkg holds:
  - typedef enum dma_state_t {IDLE, ISSUE, DRAIN, DONE};
  - constants DIR_LOAD = 0, DIR_SAVE = 1;
  - typedef struct dma_cmd_t for the latched fields.
- One sub-module, dma_lat_pipe: a parametrised RD_LAT valid shift register with an in-flight count.

Test Plan:
- Load, words=4, ext_start=0x100, stride=1, set1, bank 3, buf_start=0, RD_LAT=1 -> ext_rd_addr 0x100..0x103 on consecutive cycles; buf1_w_en=16'h0008 at buf addresses 0..3 with matching data; done 6 cycles after accept; buf2 enables never set.
- Save, words=3, stride=4, ext_start=0x20, set2, bank 0, buf_start=0x3FE, RD_LAT=2 -> buf_r_addr 0x3FE, 0x3FF, 0x000; ext_wr_addr 0x20, 0x24, 0x28; done 6 cycles after accept.
- words=0 -> no ext_re, ext_we or buffer enables; done pulses 1 cycle after accept; cmd_ready back to 1 the following cycle.
- cmd_valid held high through a 2-word transfer with a second command queued -> second command accepted only in the cycle after done; no overlap of enables between the two transfers.
- Assert rst=0 while in ISSUE (2 of 8 words issued) -> next cycle all outputs at reset values, no done; a fresh command afterwards completes normally.
- BUF_DMA_CHECKSUM_EN defined, load of data 0xFFFF, 0x0002, 0x0003 -> checksum = 0x0004 at done.
